fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Sequencer for the fetch stage's next-PC selection. It resolves branch outcomes from stage 2 against the BTB prediction and drives `PCSrc`, `PCWrite`, `ChooseEPC` and the BTB `WriteEntry` code. It holds redirects across hazard stalls and runs the exception drain/redirect and ERET sequences. It sits between the hazard/exception logic and the fetch stage.

## Interface
- `FLUSH_CYCLES`, 1: cycles `flush_if` stays high after any redirect (1..7).
- `EXC_DRAIN`, 2: cycles PC is frozen before the exception redirect (1..7).
- `CNT_W`, 16: mispredict counter width.

Ports:
- `clk` in 1: clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `stall_req` in 1: hazard unit requests PC hold.
- `br_valid` in 1: stage-2 branch resolved this cycle.
- `br_taken` in 1: actual branch outcome.
- `br_pred_taken` in 1: fetch-time prediction (BTB hit and taken), piped to stage 2.
- `br_target_ok` in 1: predicted target equals computed target.
- `jmp_valid` in 1: stage-2 jump.
- `exc_req` in 1: exception raised (pulse).
- `eret_req` in 1: exception return (pulse).
- `PCSrc` out 2: bit0 selects branch target, bit1 selects jump address.
- `PCWrite` out 1: PC update enable.
- `ChooseEPC` out 1: selects ExceptionResumeAddr.
- `WriteEntry` out 3: BTB update code.
- `flush_if` out 1: squash the IF/ID register.
- `busy` out 1: FSM is not in RUN.
- `mispredict_cnt` out CNT_W: saturating mispredict count.

## Operation
- **WriteEntry codes:**
  - `000`: none.
  - `001`: allocate (taken, predicted not-taken).
  - `010`: retarget (taken, wrong target).
  - `100`: demote (predicted taken, actually not taken). The fetch stage then uses PC_stage2+4.
- **Mispredict:** `br_valid` and either `br_taken != br_pred_taken`, or `br_taken & br_pred_taken & !br_target_ok`.
- **Mispredict redirect:**
  - Pred taken / actual not: `PCSrc=00`, `WriteEntry=100`.
  - Pred not / actual taken: `PCSrc=01`, `WriteEntry=001`.
  - Wrong target: `PCSrc=01`, `WriteEntry=010`.
  - Every case forces `PCWrite=1` and `flush_if=1`.
- **Correct prediction:** no redirect, `WriteEntry=000`.
- **Jump:** `PCSrc=10`, `PCWrite=1`, `flush_if=1`.
- **Priority (same cycle):** `exc_req` > `eret_req` > mispredict > `jmp_valid`. The loser is dropped.
- **Stall interaction:** if `stall_req` is high when a redirect is decided, the code is latched in a 1-entry pending register with `PCWrite=0`. It issues in the first cycle with `stall_req` low. While a redirect is pending, new `br_valid`/`jmp_valid` are ignored.
- **FSM states:**
  - RUN: normal operation.
  - FLUSH: `flush_if=1`, `PCWrite=!stall_req`. Lasts FLUSH_CYCLES−1 cycles after the redirect cycle, then returns to RUN. Skipped when FLUSH_CYCLES=1.
  - EXC_DRAIN: `PCWrite=0`, `flush_if=1`, for EXC_DRAIN cycles.
  - EXC_REDIRECT: 1 cycle, `ChooseEPC=1`, `PCWrite=1`, `flush_if=1`, then FLUSH or RUN.
- **ERET:** from RUN, 1 cycle with `ChooseEPC=1`, `PCWrite=1`, `flush_if=1`, then FLUSH or RUN.
- **During EXC_DRAIN:** `br_valid`, `jmp_valid` and `eret_req` are ignored and not counted. `exc_req` during FLUSH preempts and enters EXC_DRAIN; any pending redirect is cleared.
- **WriteEntry gating:** `WriteEntry` is nonzero only in the cycle the redirect issues with `PCWrite=1`, so the BTB is never written during a stall.

## Timing
- Mispredict and jump decisions are combinational in the `br_valid`/`jmp_valid` cycle when not stalled. The new PC loads at the next `clk` edge.
- The exception redirect cycle is EXC_DRAIN cycles after the `exc_req` cycle.
- **Reset** (any state, including mid-drain or pending):
  - Next state RUN; pending register cleared; counter 0.
  - Outputs: `PCSrc=00`, `PCWrite=1`, `ChooseEPC=0`, `WriteEntry=000`, `flush_if=0`, `busy=0`.
- `busy` is registered from state, high in FLUSH, EXC_DRAIN and EXC_REDIRECT.

## Configuration
- `BRPRED_STATS_EN` defined:
  - `mispredict_cnt` increments by 1 on each mispredict that issues (not when latched as pending, not when dropped).
  - It saturates at all-ones and clears on reset.
- Undefined: `mispredict_cnt` is tied to 0 and no counter flops exist.

## Structure
- Shared package `fetch_pkg`:
  - WriteEntry code constants (`WE_NONE`, `WE_ALLOC`, `WE_RETGT`, `WE_DEMOTE`).
  - PCSrc constants (`PCS_SEQ`, `PCS_BR`, `PCS_JMP`).
  - FSM state enum.
- One sub-module, `redirect_decode`: combinational, maps the branch/jump inputs to PCSrc, WriteEntry and a mispredict flag.

## Test plan
- **Pred-taken, actual not-taken:** `br_valid=1`, `br_pred_taken=1`, `br_taken=0`, no stall → same cycle `PCSrc=00`, `WriteEntry=100`, `flush_if=1`, `PCWrite=1`; counter 0→1.
- **Redirect held across stall:** pred not-taken, actual taken, with `stall_req=1` for 3 cycles → `PCWrite=0` and `WriteEntry=000` for 3 cycles. In cycle 4: `PCSrc=01`, `WriteEntry=001`, `PCWrite=1`.
- **Exception preempts branch:** `exc_req` and a mispredicting `br_valid` in the same cycle, EXC_DRAIN=2 → 2 cycles of `PCWrite=0`, `flush_if=1`. Then 1 cycle with `ChooseEPC=1`, `PCWrite=1`; counter unchanged.
- **Wrong target:** `br_taken=1`, `br_pred_taken=1`, `br_target_ok=0` → `PCSrc=01`, `WriteEntry=010`. With FLUSH_CYCLES=3, `flush_if` is high for 3 cycles and `busy` is high for 2.
- **Reset mid-drain:** `reset` asserted in the 2nd EXC_DRAIN cycle → next cycle RUN, `PCWrite=1`, `ChooseEPC=0`, `busy=0`, counter 0.
- **Counter saturation:** CNT_W=2 and 5 mispredicts with `BRPRED_STATS_EN` → count reads 3. Without the macro it reads 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch next-PC sequencer: BTB update codes,
// PC source selects, FSM states and the redirect record.
package fetch_pkg;

    localparam logic [2:0] WE_NONE   = 3'b000;
    localparam logic [2:0] WE_ALLOC  = 3'b001;
    localparam logic [2:0] WE_RETGT  = 3'b010;
    localparam logic [2:0] WE_DEMOTE = 3'b100;

    localparam logic [1:0] PCS_SEQ = 2'b00;
    localparam logic [1:0] PCS_BR  = 2'b01;
    localparam logic [1:0] PCS_JMP = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_FLUSH,
        ST_EXC_DRAIN,
        ST_EXC_REDIRECT
    } fsm_state_e;

    typedef struct packed {
        logic       vld;
        logic       mispred;
        logic [1:0] pcsrc;
        logic [2:0] we;
    } redirect_t;

endpackage

// File: rtl/redirect_decode.sv
// Maps stage-2 branch/jump resolution to a redirect record (PC select,
// BTB update code, mispredict flag). Mispredict outranks a jump.
module redirect_decode
    import fetch_pkg::*;
(
    input  logic      i_br_valid,
    input  logic      i_br_taken,
    input  logic      i_br_pred_taken,
    input  logic      i_br_target_ok,
    input  logic      i_jmp_valid,
    output redirect_t o_redir
);

    always_comb begin
        o_redir = '0;
        if (i_br_valid && (i_br_taken != i_br_pred_taken)) begin
            o_redir.vld     = 1'b1;
            o_redir.mispred = 1'b1;
            if (i_br_taken) begin
                o_redir.pcsrc = PCS_BR;
                o_redir.we    = WE_ALLOC;
            end else begin
                // demote: fetch falls back to the sequential PC of the branch
                o_redir.pcsrc = PCS_SEQ;
                o_redir.we    = WE_DEMOTE;
            end
        end else if (i_br_valid && i_br_taken && i_br_pred_taken && !i_br_target_ok) begin
            o_redir.vld     = 1'b1;
            o_redir.mispred = 1'b1;
            o_redir.pcsrc   = PCS_BR;
            o_redir.we      = WE_RETGT;
        end else if (i_jmp_valid) begin
            o_redir.vld   = 1'b1;
            o_redir.pcsrc = PCS_JMP;
            o_redir.we    = WE_NONE;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch next-PC sequencer: branch/jump redirects with stall hold, exception
// drain/redirect and ERET. BRPRED_STATS_EN enables the mispredict counter.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int EXC_DRAIN    = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic             br_pred_taken,
    input  logic             br_target_ok,
    input  logic             jmp_valid,
    input  logic             exc_req,
    input  logic             eret_req,
    output logic [1:0]       PCSrc,
    output logic             PCWrite,
    output logic             ChooseEPC,
    output logic [2:0]       WriteEntry,
    output logic             flush_if,
    output logic             busy,
    output logic [CNT_W-1:0] mispredict_cnt
);

    // Down-counter preloads: the entry cycle itself is the first cycle of each phase.
    localparam logic [2:0] FL_LOAD = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;
    localparam logic [2:0] DR_LOAD = (EXC_DRAIN > 1)    ? 3'(EXC_DRAIN - 2)    : 3'd0;
    localparam fsm_state_e ST_AFTER_RD = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    localparam fsm_state_e ST_AFTER_EX = (EXC_DRAIN > 1) ? ST_EXC_DRAIN : ST_EXC_REDIRECT;

    fsm_state_e r_state, w_nxt_state;
    logic [2:0] r_cnt, w_nxt_cnt;
    redirect_t  r_pend, w_nxt_pend;
    redirect_t  w_dec;
    redirect_t  w_act;
    logic       w_issue;

    redirect_decode u_dec (
        .i_br_valid      (br_valid),
        .i_br_taken      (br_taken),
        .i_br_pred_taken (br_pred_taken),
        .i_br_target_ok  (br_target_ok),
        .i_jmp_valid     (jmp_valid),
        .o_redir         (w_dec)
    );

    // A held redirect masks any new branch/jump decode.
    assign w_act   = r_pend.vld ? r_pend : w_dec;
    assign w_issue = (r_state == ST_RUN) && !exc_req && !eret_req && w_act.vld && !stall_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_pend  <= w_nxt_pend;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_pend  = r_pend;
        case (r_state)
            ST_RUN: begin
                if (exc_req) begin
                    w_nxt_state = ST_AFTER_EX;
                    w_nxt_cnt   = DR_LOAD;
                    w_nxt_pend  = '0;
                end else if (eret_req) begin
                    w_nxt_state = ST_AFTER_RD;
                    w_nxt_cnt   = FL_LOAD;
                    w_nxt_pend  = '0;
                end else if (w_act.vld) begin
                    if (stall_req) begin
                        w_nxt_pend = w_act;
                    end else begin
                        w_nxt_pend  = '0;
                        w_nxt_state = ST_AFTER_RD;
                        w_nxt_cnt   = FL_LOAD;
                    end
                end
            end
            ST_FLUSH: begin
                if (exc_req) begin
                    w_nxt_state = ST_AFTER_EX;
                    w_nxt_cnt   = DR_LOAD;
                    w_nxt_pend  = '0;
                end else if (r_cnt == 3'd0) begin
                    w_nxt_state = ST_RUN;
                end else begin
                    w_nxt_cnt = r_cnt - 3'd1;
                end
            end
            ST_EXC_DRAIN: begin
                if (r_cnt == 3'd0) w_nxt_state = ST_EXC_REDIRECT;
                else               w_nxt_cnt   = r_cnt - 3'd1;
            end
            ST_EXC_REDIRECT: begin
                w_nxt_state = ST_AFTER_RD;
                w_nxt_cnt   = FL_LOAD;
            end
            default: w_nxt_state = ST_RUN;
        endcase
    end

    always_comb begin
        PCSrc      = PCS_SEQ;
        PCWrite    = !stall_req;
        ChooseEPC  = 1'b0;
        WriteEntry = WE_NONE;
        flush_if   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (exc_req) begin
                    PCWrite  = 1'b0;
                    flush_if = 1'b1;
                end else if (eret_req) begin
                    ChooseEPC = 1'b1;
                    PCWrite   = 1'b1;
                    flush_if  = 1'b1;
                end else if (w_issue) begin
                    PCSrc      = w_act.pcsrc;
                    WriteEntry = w_act.we;
                    PCWrite    = 1'b1;
                    flush_if   = 1'b1;
                end
            end
            ST_FLUSH: begin
                flush_if = 1'b1;
                if (exc_req) PCWrite = 1'b0;
            end
            ST_EXC_DRAIN: begin
                PCWrite  = 1'b0;
                flush_if = 1'b1;
            end
            ST_EXC_REDIRECT: begin
                ChooseEPC = 1'b1;
                PCWrite   = 1'b1;
                flush_if  = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != ST_RUN);

`ifdef BRPRED_STATS_EN
    logic [CNT_W-1:0] r_mis_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            r_mis_cnt <= '0;
        else if (w_issue && w_act.mispred && (r_mis_cnt != '1))
            r_mis_cnt <= r_mis_cnt + CNT_W'(1);
    end

    assign mispredict_cnt = r_mis_cnt;
`else
    logic w_unused_mis;
    assign w_unused_mis   = w_act.mispred;
    assign mispredict_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed bench for fetch_redirect_ctrl (FLUSH_CYCLES=3, EXC_DRAIN=2, CNT_W=2);
// counter expectations follow BRPRED_STATS_EN.
module tb_fetch_redirect_ctrl;

    logic       clk;
    logic       reset;
    logic       stall_req, br_valid, br_taken, br_pred_taken, br_target_ok;
    logic       jmp_valid, exc_req, eret_req;
    logic [1:0] PCSrc;
    logic       PCWrite, ChooseEPC, flush_if, busy;
    logic [2:0] WriteEntry;
    logic [1:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;

    // {PCSrc, PCWrite, ChooseEPC, WriteEntry, flush_if, busy}
    localparam logic [8:0] IDLE   = 9'b00_1_0_000_0_0;
    localparam logic [8:0] FLUSHV = 9'b00_1_0_000_1_1;
    localparam logic [8:0] HOLD   = 9'b00_0_0_000_0_0;

    fetch_redirect_ctrl #(
        .FLUSH_CYCLES (3),
        .EXC_DRAIN    (2),
        .CNT_W        (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_req      (stall_req),
        .br_valid       (br_valid),
        .br_taken       (br_taken),
        .br_pred_taken  (br_pred_taken),
        .br_target_ok   (br_target_ok),
        .jmp_valid      (jmp_valid),
        .exc_req        (exc_req),
        .eret_req       (eret_req),
        .PCSrc          (PCSrc),
        .PCWrite        (PCWrite),
        .ChooseEPC      (ChooseEPC),
        .WriteEntry     (WriteEntry),
        .flush_if       (flush_if),
        .busy           (busy),
        .mispredict_cnt (mispredict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall_req = 0; br_valid = 0; br_taken = 0; br_pred_taken = 0;
        br_target_ok = 1; jmp_valid = 0; exc_req = 0; eret_req = 0;
    endtask

    task automatic chk(input string tag, input logic [8:0] exp);
        logic [8:0] obs;
        obs = {PCSrc, PCWrite, ChooseEPC, WriteEntry, flush_if, busy};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input int n);
        logic [1:0] exp;
`ifdef BRPRED_STATS_EN
        exp = (n > 3) ? 2'd3 : 2'(n);
`else
        exp = 2'd0;
`endif
        checks++;
        assert (mispredict_cnt === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, mispredict_cnt, exp);
        end
    endtask

    initial begin
        clr();
        reset = 1;
        cyc(); cyc();
        reset = 0; #1;
        chk("reset", IDLE);
        chk_cnt("reset_cnt", 0);

        // predicted taken, actually not taken
        cyc(); br_valid = 1; br_pred_taken = 1; br_taken = 0; #1;
        chk("demote", 9'b00_1_0_100_1_0);
        cyc(); clr(); #1;
        chk("demote_fl1", FLUSHV);
        chk_cnt("demote_cnt", 1);
        cyc(); #1 chk("demote_fl2", FLUSHV);
        cyc(); #1 chk("demote_run", IDLE);
        stall_req = 1; #1 chk("idle_stall", HOLD);

        // redirect held across a 3-cycle stall; jump during hold is ignored
        cyc(); br_valid = 1; br_taken = 1; br_pred_taken = 0; stall_req = 1; #1;
        chk("pend_s1", HOLD);
        cyc(); clr(); stall_req = 1; jmp_valid = 1; #1;
        chk("pend_s2", HOLD);
        cyc(); jmp_valid = 0; #1;
        chk("pend_s3", HOLD);
        chk_cnt("pend_cnt_hold", 1);
        cyc(); stall_req = 0; #1;
        chk("pend_issue", 9'b01_1_0_001_1_0);
        cyc(); #1 chk("pend_fl", FLUSHV);
        chk_cnt("pend_cnt", 2);
        cyc(); cyc(); #1 chk("pend_run", IDLE);

        // exception preempts a mispredicting branch
        cyc(); exc_req = 1; br_valid = 1; br_pred_taken = 1; br_taken = 0; #1;
        chk("exc_d1", 9'b00_0_0_000_1_0);
        cyc(); clr(); #1 chk("exc_d2", 9'b00_0_0_000_1_1);
        cyc(); #1 chk("exc_epc", 9'b00_1_1_000_1_1);
        chk_cnt("exc_cnt", 2);
        cyc(); #1 chk("exc_fl", FLUSHV);
        cyc(); cyc(); #1 chk("exc_run", IDLE);

        // wrong target: flush_if 3 cycles, busy 2
        cyc(); br_valid = 1; br_taken = 1; br_pred_taken = 1; br_target_ok = 0; #1;
        chk("retgt", 9'b01_1_0_010_1_0);
        cyc(); clr(); #1 chk("retgt_fl1", FLUSHV);
        chk_cnt("retgt_cnt", 3);
        cyc(); #1 chk("retgt_fl2", FLUSHV);
        cyc(); #1 chk("retgt_run", IDLE);

        // jump
        cyc(); jmp_valid = 1; #1 chk("jmp", 9'b10_1_0_000_1_0);
        cyc(); clr(); cyc(); cyc(); #1 chk("jmp_run", IDLE);

        // correct prediction: no redirect
        cyc(); br_valid = 1; br_taken = 1; br_pred_taken = 1; br_target_ok = 1; #1;
        chk("correct", IDLE);
        cyc(); clr(); #1 chk("correct_next", IDLE);
        chk_cnt("correct_cnt", 3);

        // eret beats a same-cycle mispredict
        cyc(); eret_req = 1; br_valid = 1; br_taken = 1; br_pred_taken = 0; #1;
        chk("eret", 9'b00_1_1_000_1_0);
        cyc(); clr(); #1 chk("eret_fl", FLUSHV);
        chk_cnt("eret_cnt", 3);
        cyc(); cyc();

        // two more mispredicts: five issued in total
        for (int i = 0; i < 2; i++) begin
            br_valid = 1; br_pred_taken = 1; br_taken = 0; #1;
            chk("sat_demote", 9'b00_1_0_100_1_0);
            cyc(); clr(); cyc(); cyc();
        end
        #1 chk_cnt("sat_cnt", 5);

        // reset in the second drain cycle
        cyc(); exc_req = 1; #1;
        cyc(); clr(); reset = 1; #1 chk("rst_drain", 9'b00_0_0_000_1_1);
        cyc(); reset = 0; #1 chk("rst_run", IDLE);
        chk_cnt("rst_cnt", 0);
        cyc(); #1 chk("rst_stay", IDLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
